// File: rtl/k12a_spi_master.sv
// CPU-mapped SPI master: DATA/CTRL/STATUS/CS registers, one 8-bit transfer per DATA
// write, programmable CPOL/CPHA/bit order and a (DIV+1)-cycle half period.
module k12a_spi_master #(
   parameter int NUM_CS    = 2,
   parameter int DIV_WIDTH = 4,
   parameter int RESET_DIV = 15
) (
   input  logic              cpu_clock,
   input  logic              reset_n,
   input  logic              io_store,
   input  logic              io_load,
   input  logic [1:0]        io_addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [NUM_CS-1:0] spi_cs_n,
   output logic              spi_irq
);

   typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_e;

   state_e               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q;
   logic [2:0]           bit_q, bit_d;
   logic                 cpol_q, cpha_q, lsb_q;
   logic                 done_q, ovr_q, mosi_q;
   logic [7:0]           tx_q, rx_sh_q, rx_buf_q;
   logic [NUM_CS-1:0]    cs_n_q;

   logic busy, half_end, lead_end, trail_end, finish, start;
   logic wr_data, wr_ctrl, wr_stat, wr_cs, rd_data;
   logic shift_en, sample;
   logic tx_first, wd_first;
   logic [7:0] tx_shift, wd_shift, rx_in, rx_next;
   logic [3:0] div_ext;
   logic [7:0] cs_ext;

   assign busy     = (state_q != IDLE);
   assign half_end = (cnt_q == div_q);
   assign wr_data  = io_store && (io_addr == 2'd0);
   assign wr_ctrl  = io_store && (io_addr == 2'd1);
   assign wr_stat  = io_store && (io_addr == 2'd2);
   assign wr_cs    = io_store && (io_addr == 2'd3);
   assign rd_data  = io_load  && (io_addr == 2'd0);
   assign start    = wr_data && !busy;

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      lead_end  = 1'b0;
      trail_end = 1'b0;
      finish    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LEAD;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         LEAD: begin
            if (half_end) begin
               lead_end = 1'b1;
               state_d  = TRAIL;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TRAIL: begin
            if (half_end) begin
               trail_end = 1'b1;
               cnt_d     = '0;
               if (bit_q == 3'd7) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = LEAD;
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // tx_q holds the bits not yet driven; mosi_q is the bit on the wire
   assign tx_first = lsb_q ? tx_q[0]  : tx_q[7];
   assign wd_first = lsb_q ? wdata[0] : wdata[7];
   assign tx_shift = lsb_q ? {1'b0, tx_q[7:1]}  : {tx_q[6:0], 1'b0};
   assign wd_shift = lsb_q ? {1'b0, wdata[7:1]} : {wdata[6:0], 1'b0};

   // The last trailing edge of a CPHA=0 transfer must not shift, so MOSI holds bit 7
   assign shift_en = cpha_q ? lead_end  : (trail_end && !finish);
   assign sample   = cpha_q ? trail_end : lead_end;
   assign rx_in    = lsb_q ? {spi_miso, rx_sh_q[7:1]} : {rx_sh_q[6:0], spi_miso};
   assign rx_next  = sample ? rx_in : rx_sh_q;

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_q     <= '0;
         mosi_q   <= 1'b0;
         rx_sh_q  <= '0;
         rx_buf_q <= '0;
      end else begin
         if (start) begin
            if (!cpha_q) begin
               mosi_q <= wd_first;
               tx_q   <= wd_shift;
            end else begin
               tx_q <= wdata;
            end
         end else if (shift_en) begin
            mosi_q <= tx_first;
            tx_q   <= tx_shift;
         end
         if (busy) rx_sh_q <= rx_next;
         if (finish) rx_buf_q <= rx_next;
      end
   end

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         cpol_q <= 1'b0;
         cpha_q <= 1'b0;
         lsb_q  <= 1'b0;
         div_q  <= DIV_WIDTH'(RESET_DIV);
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
         cs_n_q <= '1;
      end else begin
         if (wr_ctrl && !busy) begin
            cpol_q <= wdata[0];
            cpha_q <= wdata[1];
            lsb_q  <= wdata[2];
            div_q  <= wdata[4 +: DIV_WIDTH];
         end
         // A completion in the same cycle as a clear wins: the new byte is still unread
         if (finish) done_q <= 1'b1;
         else if (rd_data || (wr_stat && wdata[1])) done_q <= 1'b0;
         if (wr_data && busy) ovr_q <= 1'b1;
         else if (wr_stat && wdata[2]) ovr_q <= 1'b0;
         if (wr_cs) cs_n_q <= ~wdata[NUM_CS-1:0];
      end
   end

   always_comb begin
      div_ext = '0;
      div_ext[DIV_WIDTH-1:0] = div_q;
      cs_ext = '0;
      cs_ext[NUM_CS-1:0] = ~cs_n_q;
      rdata = '0;
      case (io_addr)
         2'd0: rdata = finish ? rx_next : rx_buf_q;
         2'd1: rdata = {div_ext, 1'b0, lsb_q, cpha_q, cpol_q};
         2'd2: rdata = {5'b0, ovr_q, done_q, busy};
         default: rdata = cs_ext;
      endcase
   end

   assign spi_sck  = cpol_q ^ (state_q == TRAIL);
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;
   assign spi_irq  = done_q;

endmodule

// File: tb/tb_k12a_spi_master.sv
// Directed + randomized bench for k12a_spi_master; a negedge monitor acts as the SPI slave
// and records bus activity, which is compared against an abstract transfer model.
module tb_k12a_spi_master;

   logic       cpu_clock = 1'b0;
   logic       reset_n   = 1'b0;
   logic       io_store  = 1'b0;
   logic       io_load   = 1'b0;
   logic [1:0] io_addr   = 2'd2;
   logic [7:0] wdata     = 8'h00;
   logic [7:0] rdata;
   logic       spi_sck, spi_mosi, spi_miso, spi_irq, slv_miso;
   logic [1:0] spi_cs_n;

   k12a_spi_master #(.NUM_CS(2), .DIV_WIDTH(4), .RESET_DIV(15)) dut (
      .cpu_clock(cpu_clock), .reset_n(reset_n), .io_store(io_store), .io_load(io_load),
      .io_addr(io_addr), .wdata(wdata), .rdata(rdata), .spi_sck(spi_sck),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .spi_irq(spi_irq)
   );

   always #5 cpu_clock = ~cpu_clock;

   int n_assert = 0;
   int n_fail   = 0;

   // transfer model configuration (written by the stimulus only)
   logic       m_cpol = 0, m_cpha = 0, m_lsb = 0, loop_en = 0, arm_req = 0;
   logic [7:0] slv_byte = 0, cur_tx = 0;
   int         exp_div = 0;

   // monitor state (written by the monitor only)
   logic arm_ack = 0, prev_sck = 0, lead;
   int   rise_cnt = 0, lead_cnt = 0, edge_cnt = 0, busy_cnt = 0;
   int   cyc = 0, last_edge = -1, min_iv = 1000, max_iv = 0, oidx = 0, iv;
   logic mosi_seen[$];

   function automatic logic mbit(input logic [7:0] b, input int k, input logic lsb);
      logic [2:0] i;
      i = 3'(k);
      return lsb ? b[i] : b[3'd7 - i];
   endfunction

   assign slv_miso = (oidx >= 0 && oidx < 8) ? mbit(slv_byte, oidx, m_lsb) : 1'b0;
   assign spi_miso = loop_en ? spi_mosi : slv_miso;

   always @(negedge cpu_clock) begin
      if (arm_req != arm_ack) begin
         arm_ack   = arm_req;
         rise_cnt  = 0; lead_cnt = 0; edge_cnt = 0; busy_cnt = 0;
         cyc       = 0; last_edge = -1; min_iv = 1000; max_iv = 0;
         oidx      = m_cpha ? -1 : 0;
         prev_sck  = spi_sck;
         mosi_seen.delete();
      end else begin
         cyc++;
         if (rdata[0]) busy_cnt++;
         if (spi_sck !== prev_sck) begin
            edge_cnt++;
            if (spi_sck) rise_cnt++;
            if (last_edge >= 0) begin
               iv = cyc - last_edge;
               if (iv < min_iv) min_iv = iv;
               if (iv > max_iv) max_iv = iv;
            end
            last_edge = cyc;
            lead = (spi_sck != m_cpol);
            if (lead) lead_cnt++;
            if (lead != m_cpha) mosi_seen.push_back(spi_mosi);
            else oidx++;
         end
         prev_sck = spi_sck;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge cpu_clock); #1;
      io_addr = a; wdata = d; io_store = 1'b1;
      @(posedge cpu_clock); #1;
      io_store = 1'b0; io_addr = 2'd2;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge cpu_clock); #1;
      io_addr = a; io_load = 1'b1;
      #1 d = rdata;
      @(posedge cpu_clock); #1;
      io_load = 1'b0; io_addr = 2'd2;
   endtask

   task automatic xfer_start(input logic [7:0] ctrl, input logic [7:0] tx,
                             input logic [7:0] slv, input logic loop);
      wr(2'd1, ctrl);
      chk("sck_idle_pre", spi_sck, ctrl[0]);
      m_cpol = ctrl[0]; m_cpha = ctrl[1]; m_lsb = ctrl[2];
      exp_div = int'(ctrl[7:4]);
      cur_tx = tx; slv_byte = slv; loop_en = loop;
      arm_req = ~arm_req;
      wr(2'd0, tx);
   endtask

   task automatic xfer_finish(input logic clr_by_status);
      logic       got;
      logic [7:0] v, obs;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge cpu_clock); #1;
         if (spi_irq) begin got = 1'b1; break; end
      end
      chk("done_seen", got, 1);
      chk("busy_cycles", busy_cnt, 16 * (exp_div + 1));
      chk("sck_rises", rise_cnt, 8);
      chk("sck_edges", edge_cnt, 16);
      chk("half_min", min_iv, exp_div + 1);
      chk("half_max", max_iv, exp_div + 1);
      chk("mosi_count", mosi_seen.size(), 8);
      obs = 8'h00;
      for (int k = 0; k < mosi_seen.size() && k < 8; k++) begin
         if (m_lsb) obs[k] = mosi_seen[k];
         else obs[7-k] = mosi_seen[k];
      end
      chk("mosi_byte", obs, cur_tx);
      chk("mosi_hold", spi_mosi, mbit(cur_tx, 7, m_lsb));
      chk("sck_idle_post", spi_sck, m_cpol);
      rd(2'd2, v);
      chk("status_done", v[1:0], 2'b10);
      if (clr_by_status) begin
         wr(2'd2, 8'h02);
         chk("irq_clr_status", spi_irq, 0);
      end
      rd(2'd0, v);
      chk("rx_byte", v, loop_en ? cur_tx : slv_byte);
      chk("irq_cleared", spi_irq, 0);
   endtask

   initial begin
      logic [7:0] v, c;
      logic       got;
      // reset state, observed while reset_n is held low
      repeat (3) @(posedge cpu_clock);
      @(negedge cpu_clock);
      io_addr = 2'd0; #1 chk("rst_data", rdata, 8'h00);
      io_addr = 2'd1; #1 chk("rst_ctrl", rdata, 8'hF0);
      io_addr = 2'd3; #1 chk("rst_cs", rdata, 8'h00);
      io_addr = 2'd2; #1 chk("rst_status", rdata, 8'h00);
      chk("rst_pins", {spi_sck, spi_mosi, spi_cs_n, spi_irq}, 5'b00110);
      reset_n = 1'b1;

      // mode 0, DIV=0, loopback
      xfer_start(8'h00, 8'hA5, 8'h00, 1'b1);
      xfer_finish(1'b0);
      // CPOL=1, CPHA=1, DIV=3 against a slave returning 0x3C
      xfer_start(8'h33, 8'h96, 8'h3C, 1'b0);
      xfer_finish(1'b0);
      // LSB-first single set bit
      xfer_start(8'h04, 8'h01, 8'h00, 1'b1);
      xfer_finish(1'b1);

      for (int n = 0; n < 6; n++) begin
         c = {4'($urandom_range(0, 3)), 1'b0, 3'($urandom)};
         xfer_start(c, 8'($urandom), 8'($urandom), 1'($urandom));
         xfer_finish(1'($urandom));
      end

      // DATA write while busy sets overrun but leaves the transfer alone
      xfer_start(8'h20, 8'h55, 8'h00, 1'b1);
      repeat (10) @(posedge cpu_clock);
      wr(2'd0, 8'hFF);
      xfer_finish(1'b0);
      rd(2'd2, v);
      chk("overrun_set", v, 8'h04);
      wr(2'd2, 8'h04);
      rd(2'd2, v);
      chk("overrun_clr", v, 8'h00);

      // CTRL write while busy is ignored
      xfer_start(8'h31, 8'($urandom), 8'($urandom), 1'b0);
      repeat (10) @(posedge cpu_clock);
      wr(2'd1, 8'h10);
      xfer_finish(1'b0);
      rd(2'd1, v);
      chk("ctrl_kept", v, 8'h31);

      // simultaneous load+store: read sees the pre-write value
      @(negedge cpu_clock); #1;
      io_addr = 2'd1; wdata = 8'h07; io_store = 1'b1; io_load = 1'b1;
      #1 v = rdata;
      @(posedge cpu_clock); #1;
      io_store = 1'b0; io_load = 1'b0; io_addr = 2'd2;
      chk("ldst_old", v, 8'h31);
      rd(2'd1, v);
      chk("ldst_new", v, 8'h07);

      // chip select, then asynchronous reset in the middle of bit 4
      wr(2'd3, 8'h02);
      chk("cs_write", spi_cs_n, 2'b01);
      xfer_start(8'h11, 8'($urandom), 8'h00, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge cpu_clock); #1;
         if (lead_cnt >= 4) begin got = 1'b1; break; end
      end
      chk("reach_bit4", got, 1);
      chk("cs_hold_xfer", spi_cs_n, 2'b01);
      @(posedge cpu_clock); #2;
      reset_n = 1'b0;
      #1;
      chk("arst_cs", spi_cs_n, 2'b11);
      chk("arst_sck", spi_sck, 0);
      chk("arst_irq", spi_irq, 0);
      chk("arst_status", rdata, 8'h00);
      @(negedge cpu_clock);
      reset_n = 1'b1;
      rd(2'd1, v);
      chk("arst_ctrl", v, 8'hF0);
      xfer_start(8'h00, 8'hC3, 8'h00, 1'b1);
      xfer_finish(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
